// File: rtl/fp_norm_stage_pkg.sv
// ============================================================================
//  Module   : fp_norm_stage_pkg
//  Purpose  : Shared widths and state encoding for the post-add normalizer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_norm_stage_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int EXP_W_DEF  = 5;
    localparam int MANT_W_DEF = 11;

    // IDLE accepts, SHIFT walks to the leading one, ROUND forms the result,
    // HOLD presents it until the consumer takes it.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ROUND = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

endpackage : fp_norm_stage_pkg

`default_nettype wire

// File: rtl/fp_round_rne.sv
// ============================================================================
//  Module   : fp_round_rne
//  Purpose  : Combinational round-to-nearest-even of a normalized magnitude
//             to MANT_W bits, with exponent bump and overflow detection.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_rne
    import fp_norm_stage_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic [WIDTH-1:0]  mag_i,
    input  logic              sticky_i,
    input  logic [EXP_W-1:0]  exp_i,
    output logic [MANT_W-1:0] mant_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic              ovf_o
);

    localparam logic [EXP_W-1:0]  EXP_MAX  = '1;
    localparam logic [MANT_W-1:0] MANT_ONE = MANT_W'(1) << (MANT_W - 1);

    logic [MANT_W-1:0] mant_t;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [MANT_W:0]   sum;
    logic [EXP_W-1:0]  exp_inc;

    assign mant_t  = mag_i[WIDTH-1 -: MANT_W];
    assign guard   = mag_i[WIDTH-MANT_W-1];
    assign sticky  = (|mag_i[WIDTH-MANT_W-2:0]) | sticky_i;
    assign inc     = guard & (sticky | mant_t[0]);
    assign sum     = {1'b0, mant_t} + {{MANT_W{1'b0}}, inc};
    assign exp_inc = exp_i + 1'b1;

    // Select rounded mantissa; a carry out of the mantissa renormalizes by one.
    always_comb begin
        mant_o = sum[MANT_W-1:0];
        exp_o  = exp_i;
        ovf_o  = 1'b0;
        if (exp_i == EXP_MAX) begin
            mant_o = '0;
            ovf_o  = 1'b1;
        end else if (sum[MANT_W]) begin
            exp_o  = exp_inc;
            mant_o = MANT_ONE;
            if (exp_inc == EXP_MAX) begin
                mant_o = '0;
                ovf_o  = 1'b1;
            end
        end
    end

endmodule : fp_round_rne

`default_nettype wire

// File: rtl/fp_norm_stage.sv
// ============================================================================
//  Module   : fp_norm_stage
//  Purpose  : Post-add normalizer. Shifts the add/sub magnitude left one bit
//             per clock to the leading one, adjusts the exponent, and
//             truncates (default) or rounds to MANT_W bits. Result is held on
//             a valid/ready handshake with zero/overflow/underflow flags.
//  Options  : ROUND_NEAREST_EN - round-to-nearest-even instead of truncation
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_norm_stage
    import fp_norm_stage_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_mag,
    input  logic              in_carry,
    input  logic              in_neg,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf
);

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mag_q,   mag_d;
    logic [EXP_W-1:0]  exp_q,   exp_d;
    logic              sign_q,  sign_d;
    logic [EXP_W-1:0]  oexp_q,  oexp_d;
    logic [MANT_W-1:0] mant_q,  mant_d;
    logic              zero_q,  zero_d;
    logic              ovf_q,   ovf_d;
    logic              unf_q,   unf_d;

`ifdef ROUND_NEAREST_EN
    logic              sticky_q, sticky_d;
    logic [MANT_W-1:0] rnd_mant;
    logic [EXP_W-1:0]  rnd_exp;
    logic              rnd_ovf;

    fp_round_rne #(
        .WIDTH  (WIDTH),
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_round (
        .mag_i    (mag_q),
        .sticky_i (sticky_q),
        .exp_i    (exp_q),
        .mant_o   (rnd_mant),
        .exp_o    (rnd_exp),
        .ovf_o    (rnd_ovf)
    );
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign out_sign  = sign_q;
    assign out_exp   = oexp_q;
    assign out_mant  = mant_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;

    // Next-state and datapath update for the accept/shift/round/hold sequence.
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        oexp_d  = oexp_q;
        mant_d  = mant_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
`ifdef ROUND_NEAREST_EN
        sticky_d = sticky_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = in_neg;
                    zero_d = 1'b0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    if (in_carry) begin
                        // Carry-out: right-shift once; saturate so a full
                        // exponent never wraps and still reports overflow.
                        mag_d = {1'b1, in_mag[WIDTH-1:1]};
                        exp_d = (in_exp == EXP_MAX) ? EXP_MAX : in_exp + 1'b1;
`ifdef ROUND_NEAREST_EN
                        sticky_d = in_mag[0];
`endif
                        state_d = S_ROUND;
                    end else if (in_mag == '0) begin
                        zero_d  = 1'b1;
                        oexp_d  = '0;
                        mant_d  = '0;
                        state_d = S_HOLD;
                    end else begin
                        mag_d = in_mag;
                        exp_d = in_exp;
`ifdef ROUND_NEAREST_EN
                        sticky_d = 1'b0;
`endif
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (mag_q[WIDTH-1] || (exp_q == '0)) begin
                    unf_d   = ~mag_q[WIDTH-1];
                    state_d = S_ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 1'b1;
                end
            end
            S_ROUND: begin
`ifdef ROUND_NEAREST_EN
                mant_d = rnd_mant;
                oexp_d = rnd_exp;
                ovf_d  = rnd_ovf;
`else
                oexp_d = exp_q;
                if (exp_q == EXP_MAX) begin
                    mant_d = '0;
                    ovf_d  = 1'b1;
                end else begin
                    mant_d = mag_q[WIDTH-1 -: MANT_W];
                end
`endif
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operand in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mag_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            oexp_q  <= '0;
            mant_q  <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
`ifdef ROUND_NEAREST_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            oexp_q  <= oexp_d;
            mant_q  <= mant_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
`ifdef ROUND_NEAREST_EN
            sticky_q <= sticky_d;
`endif
        end
    end

endmodule : fp_norm_stage

`default_nettype wire

// File: tb/tb_fp_norm_stage.sv
// ============================================================================
//  Module   : tb_fp_norm_stage
//  Purpose  : Self-checking bench for fp_norm_stage (directed + random).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_norm_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_mag = '0;
    logic        in_carry = 1'b0;
    logic        in_neg = 1'b0;
    logic [4:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign;
    logic [4:0]  out_exp;
    logic [10:0] out_mant;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;

    int checks = 0;
    int errors = 0;

    // Last observed result, for constant checks on the directed cases.
    logic [4:0]  obs_exp;
    logic [10:0] obs_mant;
    logic        obs_ovf, obs_unf, obs_zero, obs_sign;
    int          obs_lat;

    fp_norm_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_carry  (in_carry),
        .in_neg    (in_neg),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: normalize by counting leading zeros, then truncate/round
    // using integer arithmetic on the retained bits.
    task automatic model(input logic [15:0] mag, input logic c, input logic [4:0] e_in,
                         output int lat, output logic [4:0] e_o, output logic [10:0] m_o,
                         output logic z, output logic ovf, output logic unf);
        logic [16:0] v;
        int k, s, e, m;
        logic g, st;
        z = 1'b0; ovf = 1'b0; unf = 1'b0;
        if (c) begin
            v   = {1'b1, mag};
            e   = (e_in == 5'd31) ? 31 : int'(e_in) + 1;
            lat = 2;
        end else if (mag == 16'd0) begin
            z = 1'b1; lat = 1; e_o = '0; m_o = '0;
            return;
        end else begin
            k = 0;
            while (!mag[15-k]) k++;
            s   = (k < int'(e_in)) ? k : int'(e_in);
            unf = (k > int'(e_in));
            lat = s + 3;
            v   = {16'(mag << s), 1'b0};
            e   = int'(e_in) - s;
        end
        m  = int'(v[16:6]);
        g  = v[5];
        st = |v[4:0];
`ifdef ROUND_NEAREST_EN
        if (g && (st || (m % 2 == 1))) m++;
        if (m == 2048) begin
            m = 1024;
            e++;
        end
`else
        if (g && st) m = m + 0;
`endif
        if (e >= 31) begin
            ovf = 1'b1; e_o = 5'd31; m_o = '0;
        end else begin
            e_o = 5'(e); m_o = 11'(m);
        end
    endtask

    // Issue one operand, measure latency, check result, hold for `hold` cycles.
    task automatic do_op(input logic [15:0] mag, input logic c, input logic n,
                         input logic [4:0] e, input int hold);
        int lat_exp, lat;
        logic [4:0]  ee;
        logic [10:0] em;
        logic ez, eo, eu;
        model(mag, c, e, lat_exp, ee, em, ez, eo, eu);
        @(negedge clk);
        in_valid = 1'b1; in_mag = mag; in_carry = c; in_neg = n; in_exp = e;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        obs_lat = lat; obs_exp = out_exp; obs_mant = out_mant;
        obs_ovf = out_ovf; obs_unf = out_unf; obs_zero = out_zero; obs_sign = out_sign;
        check("latency", 32'(lat), 32'(lat_exp));
        check("exp",  32'(out_exp),  32'(ee));
        check("mant", 32'(out_mant), 32'(em));
        check("flags", {28'd0, out_zero, out_ovf, out_unf, out_sign}, {28'd0, ez, eo, eu, n});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_stable", {15'd0, out_valid, in_ready, out_exp, out_mant},
                                 {15'd0, 1'b1, 1'b0, ee, em});
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check("release", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    initial begin
        int seen;
        logic [15:0] rm;
        // Reset state
        #12;
        check("rst_outputs", {9'd0, out_valid, out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf}, 32'd0);
        @(negedge clk); rst = 1'b0;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: already normalized
        do_op(16'h8000, 1'b0, 1'b0, 5'd15, 0);
        check("t1_lat", 32'(obs_lat), 32'd3);
        check("t1_res", {16'd0, obs_exp, obs_mant}, {16'd0, 5'd15, 11'h400});
        // 2: fifteen shifts
        do_op(16'h0001, 1'b0, 1'b0, 5'd20, 0);
        check("t2_lat", 32'(obs_lat), 32'd18);
        check("t2_res", {16'd0, obs_exp, obs_mant}, {16'd0, 5'd5, 11'h400});
        // 3: carry into overflow
        do_op(16'hFFFF, 1'b1, 1'b0, 5'd30, 0);
        check("t3_res", {15'd0, obs_ovf, obs_exp, obs_mant}, {15'd0, 1'b1, 5'd31, 11'h000});
        // 4: zero magnitude, negative
        do_op(16'h0000, 1'b0, 1'b1, 5'd9, 0);
        check("t4_res", {14'd0, obs_zero, obs_sign, obs_exp, obs_mant}, {14'd0, 1'b1, 1'b1, 5'd0, 11'h000});
        // 5: underflow stops at exponent 0
        do_op(16'h0003, 1'b0, 1'b0, 5'd3, 0);
        check("t5_res", {15'd0, obs_unf, obs_exp, obs_mant}, {15'd0, 1'b1, 5'd0, 11'h000});
        // 6: rounding case with back-pressure
        do_op(16'h801F, 1'b0, 1'b0, 5'd10, 4);
`ifdef ROUND_NEAREST_EN
        check("t6_mant", 32'(obs_mant), 32'h401);
`else
        check("t6_mant", 32'(obs_mant), 32'h400);
`endif

        // Reset asserted mid-SHIFT aborts the operand
        @(negedge clk);
        in_valid = 1'b1; in_mag = 16'h0001; in_carry = 1'b0; in_exp = 5'd20;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("abort_valid", 32'(out_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_output", 32'(seen), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);

        // Random operands
        for (int i = 0; i < 150; i++) begin
            rm = 16'($urandom) >> $urandom_range(0, 16);
            do_op(rm, ($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom),
                  $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fp_norm_stage

`default_nettype wire
